// File: rtl/i2c_poll_sched_pkg.sv
// i2c_poll_pkg: shared state encoding and error codes for the I2C poll scheduler
package i2c_poll_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} poll_state_t;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
endpackage

// File: rtl/i2c_poll_sched_tick_timeout.sv
// tick_timeout: counts enabled tick pulses and flags the tick that reaches LIMIT
module tick_timeout #(
  parameter int LIMIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  input  logic tick_i,
  output logic expired_o
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] TOP  = W'(LIMIT);
  logic [W-1:0] cnt_q;
  // saturates at LIMIT so a stuck enable can never wrap back to a live count
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && tick_i && cnt_q != TOP) cnt_q <= cnt_q + W'(1);
  assign expired_o = en_i && tick_i && cnt_q == LAST;
endmodule

// File: rtl/i2c_poll_sched.sv
// i2c_poll_sched: on each poll tick reads NUM_REGS bytes over I2C and publishes them atomically
module i2c_poll_sched
  import i2c_poll_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter logic [7:0] BASE_REG   = 8'h00,
  parameter int         NUM_REGS   = 3,
  parameter int         TIMEOUT_MS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick_poll,
  input  logic                  tick_ms,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [6:0]            cmd_dev_addr,
  output logic [7:0]            cmd_reg_addr,
  input  logic                  rsp_valid,
  input  logic [7:0]            rsp_data,
  input  logic                  rsp_err,
  output logic [8*NUM_REGS-1:0] sample,
  output logic                  data_valid,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic                  busy,
  output logic [7:0]            overrun_cnt
);
  localparam int IW = $clog2(NUM_REGS + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
  poll_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_REGS-1:0][7:0] shadow_q, shadow_d;
  logic [8*NUM_REGS-1:0] sample_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, ovr_q;
  logic [1:0] ec_q;
  logic dv_q, ep_q, to_fire;
  tick_timeout #(.LIMIT(TIMEOUT_MS)) u_timeout (
    .clk,
    .rst_n,
    .clr_i    (state_q == ISSUE && cmd_ready),
    .en_i     (state_q == WAIT),
    .tick_i   (tick_ms),
    .expired_o(to_fire)
  );
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE:  if (tick_poll) begin
        state_d = ISSUE;
        idx_d   = '0;
      end
      ISSUE: if (cmd_ready) state_d = WAIT;
      WAIT:  if (rsp_valid && rsp_err) state_d = ERR;
      else if (rsp_valid) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (idx_q == IW'(i)) shadow_d[i] = rsp_data;
        state_d = idx_q == LAST ? DONE : ISSUE;
        idx_d   = idx_q == LAST ? idx_q : idx_q + IW'(1);
      end else if (to_fire) state_d = ERR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      dev_q    <= '0;
      reg_q    <= '0;
      ovr_q    <= '0;
      ec_q     <= ERR_NONE;
      dv_q     <= 1'b0;
      ep_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      dv_q     <= state_d == DONE;
      ep_q     <= state_d == ERR;
      if (state_d == DONE) begin
        sample_q <= shadow_d;
        ec_q     <= ERR_NONE;
      end
      // ERR is only reachable from WAIT, where a strobe means NACK and its absence means timeout
      if (state_d == ERR) ec_q <= rsp_valid ? ERR_NACK : ERR_TIMEOUT;
      if (state_d == ISSUE) begin
        dev_q <= DEV_ADDR;
        reg_q <= BASE_REG + 8'(idx_d);
      end
      if (tick_poll && state_q != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end
  assign cmd_valid    = state_q == ISSUE;
  assign busy         = state_q != IDLE;
  assign cmd_dev_addr = dev_q;
  assign cmd_reg_addr = reg_q;
  assign sample       = sample_q;
  assign data_valid   = dv_q;
  assign err_pulse    = ep_q;
  assign err_code     = ec_q;
  assign overrun_cnt  = ovr_q;
endmodule

// File: tb/tb_i2c_poll_sched.sv
// tb_i2c_poll_sched: directed scenarios plus random traffic checked against a transaction-level model
module tb_i2c_poll_sched;
  localparam int N  = 3;
  localparam int TO = 10;
  localparam logic [6:0] DEV  = 7'h68;
  localparam logic [7:0] BASE = 8'h00;
  logic clk, rst_n, tick_poll, tick_ms, cmd_valid, cmd_ready, rsp_valid, rsp_err;
  logic data_valid, err_pulse, busy;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr, rsp_data, overrun_cnt;
  logic [8*N-1:0] sample;
  logic [1:0] err_code;
  i2c_poll_sched #(.DEV_ADDR(DEV), .BASE_REG(BASE), .NUM_REGS(N), .TIMEOUT_MS(TO)) dut (
    .clk(clk), .rst_n(rst_n), .tick_poll(tick_poll), .tick_ms(tick_ms),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev_addr(cmd_dev_addr),
    .cmd_reg_addr(cmd_reg_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .sample(sample), .data_valid(data_valid), .err_pulse(err_pulse),
    .err_code(err_code), .busy(busy), .overrun_cnt(overrun_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: phase 0 idle, 1 command outstanding, 2 awaiting byte, 3 publish, 4 abort
  int m_ph, m_idx, m_tc, m_ovr;
  logic [7:0] m_sh[N];
  logic [8*N-1:0] m_sample;
  bit m_dv, m_ep;
  logic [1:0] m_ec;
  task automatic model_step();
    int ph = m_ph;
    m_dv = 0;
    m_ep = 0;
    if (tick_poll && ph != 0 && m_ovr < 255) m_ovr++;
    if (ph == 0) begin
      if (tick_poll) begin m_idx = 0; m_ph = 1; end
    end else if (ph == 1) begin
      if (cmd_ready) begin m_tc = 0; m_ph = 2; end
    end else if (ph == 2) begin
      if (rsp_valid && rsp_err) begin m_ph = 4; m_ec = 2'd1; m_ep = 1; end
      else if (rsp_valid) begin
        m_sh[m_idx] = rsp_data;
        if (m_idx == N - 1) begin
          m_ph = 3; m_dv = 1; m_ec = 2'd0;
          for (int i = 0; i < N; i++) m_sample[8*i+:8] = m_sh[i];
        end else begin m_idx++; m_ph = 1; end
      end else if (tick_ms) begin
        m_tc++;
        if (m_tc == TO) begin m_ph = 4; m_ec = 2'd2; m_ep = 1; end
      end
    end else m_ph = 0;
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = 0; m_idx = 0; m_tc = 0; m_ovr = 0; m_sample = '0; m_dv = 0; m_ep = 0; m_ec = 2'd0;
    end else model_step();
  end
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("cmd_valid", cmd_valid, m_ph == 1);
      chk("busy", busy, m_ph != 0);
      chk("sample", sample, m_sample);
      chk("data_valid", data_valid, m_dv);
      chk("err_pulse", err_pulse, m_ep);
      chk("err_code", err_code, m_ec);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      if (m_ph == 1) begin
        chk("cmd_reg_addr", cmd_reg_addr, 8'(BASE + m_idx));
        chk("cmd_dev_addr", cmd_dev_addr, DEV);
      end
    end
  end
  bit hs_seen;
  logic [7:0] hs_log[$];
  initial forever begin
    @(negedge clk);
    hs_seen = rst_n && cmd_valid && cmd_ready;
    if (hs_seen) hs_log.push_back(cmd_reg_addr);
  end
  bit auto_rsp = 0;
  int cd = 0;
  task automatic cyc();
    @(posedge clk);
    #1;
    tick_poll = 0; tick_ms = 0; rsp_valid = 0; rsp_err = 0;
    if (auto_rsp) begin
      if (hs_seen) cd = 1 + int'($urandom % 30);
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          rsp_valid = 1; rsp_data = 8'($urandom); rsp_err = ($urandom % 8 == 0);
        end
      end
    end
  endtask
  task automatic wait_hs();
    int n = 0;
    do begin cyc(); n++; end while (!hs_seen && n < 200);
    chk("handshake_within_budget", hs_seen, 1);
  endtask
  task automatic byte_rsp(input logic [7:0] d, input bit e, input int nt, input int dly, input bit resp);
    wait_hs();
    for (int c = 0; c < dly; c++) begin
      if (c > 0) cyc();
      tick_ms = (c >= dly - nt);
      if (resp && c == dly - 1) begin rsp_valid = 1; rsp_data = d; rsp_err = e; end
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin cyc(); n++; end
    chk("idle_within_budget", busy, 0);
  endtask
  task automatic chk_all_zero(input string nm);
    chk({nm, "_cmd_valid"}, cmd_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_sample"}, sample, 0);
    chk({nm, "_data_valid"}, data_valid, 0);
    chk({nm, "_err_pulse"}, err_pulse, 0);
    chk({nm, "_err_code"}, err_code, 0);
    chk({nm, "_overrun"}, overrun_cnt, 0);
    chk({nm, "_reg_addr"}, cmd_reg_addr, 0);
    chk({nm, "_dev_addr"}, cmd_dev_addr, 0);
  endtask
  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 0; tick_poll = 0; tick_ms = 0; cmd_ready = 0; rsp_valid = 0; rsp_err = 0; rsp_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1;
    cyc(); cyc();
    hs_log.delete();
    cmd_ready = 1; tick_poll = 1;
    byte_rsp(8'hA1, 0, 0, 5, 1);
    byte_rsp(8'hB2, 0, 0, 5, 1);
    byte_rsp(8'hC3, 0, 0, 5, 1);
    cyc();
    chk("nom_data_valid", data_valid, 1);
    chk("nom_sample", sample, 24'hC3B2A1);
    chk("nom_err_code", err_code, 0);
    chk("nom_dev_addr", cmd_dev_addr, 7'h68);
    cyc();
    chk("nom_busy_after", busy, 0);
    chk("nom_cmd_count", hs_log.size(), 3);
    for (int i = 0; i < 3 && i < hs_log.size(); i++) chk("nom_reg_addr_seq", hs_log[i], i);
    cmd_ready = 0; tick_poll = 1;
    cyc();
    for (int i = 0; i < 20; i++) begin cyc(); tick_ms = (i == 10); end
    cmd_ready = 1;
    byte_rsp(8'h11, 0, 0, 3, 1);
    byte_rsp(8'h22, 0, 0, 3, 1);
    byte_rsp(8'h33, 0, 0, 3, 1);
    wait_idle();
    chk("bp_sample", sample, 24'h332211);
    chk("bp_err_code", err_code, 0);
    tick_poll = 1;
    byte_rsp(8'h44, 0, 0, 2, 1);
    byte_rsp(8'h55, 1, 0, 2, 1);
    cyc();
    chk("nack_err_pulse", err_pulse, 1);
    chk("nack_err_code", err_code, 1);
    chk("nack_busy_in_err", busy, 1);
    chk("nack_sample_kept", sample, 24'h332211);
    cyc();
    chk("nack_busy_falls", busy, 0);
    chk("nack_pulse_single", err_pulse, 0);
    chk("nack_code_holds", err_code, 1);
    tick_poll = 1;
    byte_rsp(8'h66, 0, 0, 2, 1);
    byte_rsp(8'h77, 0, 0, 2, 1);
    byte_rsp(8'h88, 0, 0, 2, 1);
    wait_idle();
    chk("recover_err_code", err_code, 0);
    chk("recover_sample", sample, 24'h887766);
    tick_poll = 1;
    byte_rsp(8'h00, 0, TO, TO, 0);
    cyc();
    chk("timeout_err_pulse", err_pulse, 1);
    chk("timeout_err_code", err_code, 2);
    wait_idle();
    chk("timeout_sample_kept", sample, 24'h887766);
    tick_poll = 1;
    byte_rsp(8'h99, 0, 0, 1, 1);
    byte_rsp(8'hAA, 0, 0, 1, 1);
    byte_rsp(8'hBB, 0, TO, TO, 1);
    cyc();
    chk("race_data_valid", data_valid, 1);
    chk("race_no_err_pulse", err_pulse, 0);
    chk("race_sample", sample, 24'hBBAA99);
    chk("race_err_code", err_code, 0);
    wait_idle();
    hs_log.delete();
    cmd_ready = 0; tick_poll = 1;
    cyc();
    for (int i = 0; i < 6; i++) begin cyc(); tick_poll = (i % 2 == 0); end
    cmd_ready = 1;
    byte_rsp(8'h01, 0, 0, 2, 1);
    byte_rsp(8'h02, 0, 0, 2, 1);
    byte_rsp(8'h03, 0, 0, 2, 1);
    wait_idle();
    chk("ovr_three", overrun_cnt, 3);
    repeat (5) cyc();
    chk("ovr_one_burst", hs_log.size(), 3);
    chk("ovr_no_restart", busy, 0);
    tick_poll = 1;
    byte_rsp(8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 300; i++) begin cyc(); tick_poll = 1; end
    chk("ovr_saturate", overrun_cnt, 255);
    chk("stall_busy", busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk_all_zero("async_reset");
    cyc(); cyc();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin cyc(); chk("post_reset_quiet", cmd_valid, 0); end
    auto_rsp = 1; cd = 0;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      tick_poll = ($urandom % 25 == 0);
      tick_ms   = ($urandom % 3 == 0);
      cmd_ready = ($urandom % 3 != 0);
    end
    auto_rsp = 0;
    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
